// File: rtl/move_ctrl.sv
// move_ctrl: player motion controller for the Donkey Kong core.
// Turns the 4-bit move_state code into a registered pixel position, facing,
// jump status and walk-animation frame, advancing once per motion tick.
// Optional feature: define MOVE_AIR_CTRL_EN to let live left/right input
// steer x while jumping; otherwise the direction is latched at take-off.
module move_ctrl #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int X_MIN     = 16,
  parameter int X_MAX     = 608,
  parameter int X_START   = 32,
  parameter int Y_TOP     = 32,
  parameter int Y_GROUND  = 440,
  parameter int X_STEP    = 2,
  parameter int JUMP_STEP = 2,
  parameter int JUMP_H    = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] move_state,
  input  logic       on_ladder,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       facing,
  output logic       jumping,
  output logic [1:0] anim_frame,
  output logic       tick
);

  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RISE, FALL} jstate_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

  logic [CW-1:0] cnt;
  logic          upd;
  jstate_t       state;
  logic          arm;
  logic [8:0]    h;
  logic [2:0]    sub;
  dir_t          air_dir;

  dir_t          live_dir;
  dir_t          step_dir;
  logic          climb_up;
  logic          climb_dn;
  logic          start_jump;
  logic [9:0]    x_next;
  logic          facing_next;

  // The update cycle is the last count of the tick divider.
  assign upd = (cnt == CW'(TICK_DIV - 1));

  // Tick divider: free-running 0 .. TICK_DIV-1.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst)      cnt <= '0;
    else if (upd) cnt <= '0;
    else          cnt <= cnt + CW'(1);
  end

  // Decode the move code and compute the horizontal step for this tick.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    live_dir    = DIR_NONE;
    climb_up    = 1'b0;
    climb_dn    = 1'b0;
    x_next      = x;
    facing_next = facing;

    case (move_state[2:0])
      3'b001:  climb_up = 1'b1;
      3'b010:  live_dir = DIR_LEFT;
      3'b011:  live_dir = DIR_RIGHT;
      3'b100:  climb_dn = 1'b1;
      default: ;
    endcase

    start_jump = (state == IDLE) && arm && move_state[3] && !on_ladder;

`ifdef MOVE_AIR_CTRL_EN
    step_dir = live_dir;
`else
    // Airborne, the take-off direction keeps driving x.
    step_dir = (state == IDLE) ? live_dir : air_dir;
`endif

    // Compare against the limit first so the subtraction never wraps.
    case (step_dir)
      DIR_LEFT: begin
        x_next      = (x > 10'(X_MIN + X_STEP)) ? x - 10'(X_STEP) : 10'(X_MIN);
        facing_next = 1'b0;
      end
      DIR_RIGHT: begin
        x_next      = (x < 10'(X_MAX - X_STEP)) ? x + 10'(X_STEP) : 10'(X_MAX);
        facing_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Jump FSM, climbing, horizontal motion and animation, all per update cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      x          <= 10'(X_START);
      y          <= 9'(Y_GROUND);
      facing     <= 1'b1;
      jumping    <= 1'b0;
      anim_frame <= 2'd0;
      tick       <= 1'b0;
      state      <= IDLE;
      arm        <= 1'b1;
      h          <= '0;
      sub        <= '0;
      air_dir    <= DIR_NONE;
    end else begin
      tick <= upd;
      if (upd) begin
        x      <= x_next;
        facing <= facing_next;

        // Releasing the jump key re-arms; a held key cannot retrigger.
        if (!move_state[3]) arm <= 1'b1;

        case (state)
          IDLE: begin
            if (start_jump) begin
              state   <= RISE;
              jumping <= 1'b1;
              h       <= '0;
              arm     <= 1'b0;
              air_dir <= live_dir;
            end else if (on_ladder && climb_up) begin
              y <= (y > 9'(Y_TOP)) ? y - 9'd1 : 9'(Y_TOP);
            end else if (on_ladder && climb_dn) begin
              y <= (y < 9'(Y_GROUND)) ? y + 9'd1 : 9'(Y_GROUND);
            end

            // Walk cycle advances on left/right; anything else resets it.
            if (live_dir != DIR_NONE) begin
              sub <= sub + 3'd1;
              if (sub == 3'd7) anim_frame <= anim_frame + 2'd1;
            end else begin
              sub        <= '0;
              anim_frame <= 2'd0;
            end
          end

          RISE: begin
            y <= y - 9'(JUMP_STEP);
            h <= h + 9'(JUMP_STEP);
            if (h + 9'(JUMP_STEP) == 9'(JUMP_H)) state <= FALL;
          end

          FALL: begin
            if ({1'b0, y} + 10'(JUMP_STEP) >= 10'(Y_GROUND)) begin
              y       <= 9'(Y_GROUND);
              state   <= IDLE;
              jumping <= 1'b0;
            end else begin
              y <= y + 9'(JUMP_STEP);
            end
          end

          default: begin
            state   <= IDLE;
            jumping <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_ctrl.sv
// Testbench for move_ctrl with TICK_DIV=4: a vector table for walking and
// climbing, plus hand-written reset, jump, air-control and reset-mid-jump
// sequences. Expected outputs are queued when a tick's inputs are driven and
// compared when the tick pulse appears.
module tb_move_ctrl;

  localparam int TD = 4;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       f;
    logic       j;
    logic [1:0] a;
  } exp_t;

  typedef struct {
    logic [3:0] ms;
    logic       lad;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] move_state = 4'b0000;
  logic       on_ladder = 1'b0;
  logic [9:0] x;
  logic [8:0] y;
  logic       facing;
  logic       jumping;
  logic [1:0] anim_frame;
  logic       tick;

  int total = 0;
  int bad   = 0;

  exp_t sb[$];
  vec_t vecs[$];

  move_ctrl #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst        (rst),
    .move_state (move_state),
    .on_ladder  (on_ladder),
    .x          (x),
    .y          (y),
    .facing     (facing),
    .jumping    (jumping),
    .anim_frame (anim_frame),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, want);
    end
  endtask

  function automatic exp_t mk_e(input int ex, input int ey, input logic ef,
                                input logic ej, input int ea);
    exp_t e;
    e.x = 10'(ex);
    e.y = 9'(ey);
    e.f = ef;
    e.j = ej;
    e.a = 2'(ea);
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] ms, input logic lad, input int ex,
                              input int ey, input logic ef, input logic ej, input int ea);
    vec_t v;
    v.ms  = ms;
    v.lad = lad;
    v.e   = mk_e(ex, ey, ef, ej, ea);
    return v;
  endfunction

  function automatic int clamp_left(input int cur);
    return (cur - 2 < 16) ? 16 : cur - 2;
  endfunction

  // Drive one tick's inputs, queue its expected outputs, wait for the tick
  // pulse (bounded) and compare; then confirm the pulse lasted one clock.
  task automatic step(input logic [3:0] ms, input logic lad, input exp_t e, input string name);
    exp_t want;
    int   n;
    move_state = ms;
    on_ladder  = lad;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 3 * TD);
    want = sb.pop_front();
    if (!tick) begin
      check({name, " tick timeout"}, 32'(tick), 32'd1);
      return;
    end
    check({name, " x"},      32'(x),          32'(want.x));
    check({name, " y"},      32'(y),          32'(want.y));
    check({name, " facing"}, 32'(facing),     32'(want.f));
    check({name, " jump"},   32'(jumping),    32'(want.j));
    check({name, " anim"},   32'(anim_frame), 32'(want.a));
    @(negedge clk);
    check({name, " tick width"}, 32'(tick), 32'd0);
  endtask

  initial begin
    int   n;
    int   ax;
    int   ey;
    exp_t e;

    // Vector table: walk left into the wall, stop, step right, climb.
    for (int k = 1; k <= 10; k++)
      vecs.push_back(mk(4'b0010, 1'b0, (32 - 2 * k < 16) ? 16 : 32 - 2 * k, 440, 1'b0, 1'b0,
                        (k >= 8) ? 1 : 0));
    vecs.push_back(mk(4'b0000, 1'b0, 16, 440, 1'b0, 1'b0, 0));
    vecs.push_back(mk(4'b0011, 1'b0, 18, 440, 1'b1, 1'b0, 0));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(4'b0001, 1'b1, 18, 440 - k, 1'b1, 1'b0, 0));
    vecs.push_back(mk(4'b0001, 1'b0, 18, 435, 1'b1, 1'b0, 0));
    for (int k = 1; k <= 6; k++)
      vecs.push_back(mk(4'b0100, 1'b1, 18, (435 + k > 440) ? 440 : 435 + k, 1'b1, 1'b0, 0));

    // Reset: held three clocks, then the first tick four clocks after release.
    repeat (3) @(negedge clk);
    check("reset x",      32'(x),          32'd32);
    check("reset y",      32'(y),          32'd440);
    check("reset facing", 32'(facing),     32'd1);
    check("reset jump",   32'(jumping),    32'd0);
    check("reset anim",   32'(anim_frame), 32'd0);
    check("reset tick",   32'(tick),       32'd0);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 3 * TD);
    check("first tick latency", 32'(n), 32'd4);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].ms, vecs[i].lad, vecs[i].e, $sformatf("vec%0d", i));

    // Full jump from the floor with the key held throughout.
    step(4'b1000, 1'b0, mk_e(18, 440, 1'b1, 1'b1, 0), "jump start");
    for (int k = 1; k <= 40; k++) begin
      ey = (k <= 20) ? 440 - 2 * k : 400 + 2 * (k - 20);
      step(4'b1000, 1'b0, mk_e(18, ey, 1'b1, (k < 40), 0), $sformatf("jump t%0d", k));
    end
    step(4'b1000, 1'b0, mk_e(18, 440, 1'b1, 1'b0, 0), "held key no retrigger a");
    step(4'b1000, 1'b0, mk_e(18, 440, 1'b1, 1'b0, 0), "held key no retrigger b");
    step(4'b0000, 1'b0, mk_e(18, 440, 1'b1, 1'b0, 0), "release key");

    // Air control: jump straight up, press right from tick 3.
    step(4'b1000, 1'b0, mk_e(18, 440, 1'b1, 1'b1, 0), "air start");
    ax = 18;
    for (int k = 1; k <= 40; k++) begin
`ifdef MOVE_AIR_CTRL_EN
      if (k >= 3) ax = ax + 2;
`endif
      ey = (k <= 20) ? 440 - 2 * k : 400 + 2 * (k - 20);
      step((k >= 3) ? 4'b0011 : 4'b1000, 1'b0, mk_e(ax, ey, 1'b1, (k < 40), 0),
           $sformatf("air t%0d", k));
    end
    ax = ax + 2;
    step(4'b0011, 1'b0, mk_e(ax, 440, 1'b1, 1'b0, 0), "air landed walk");

    // Jump with left on take-off, then release and reset on RISE tick 10.
    ax = clamp_left(ax);
    step(4'b1010, 1'b0, mk_e(ax, 440, 1'b0, 1'b1, 0), "left jump start");
    for (int k = 1; k <= 10; k++) begin
`ifndef MOVE_AIR_CTRL_EN
      ax = clamp_left(ax);
`endif
      step(4'b0000, 1'b0, mk_e(ax, 440 - 2 * k, 1'b0, 1'b1, 0), $sformatf("left jump t%0d", k));
    end
    rst = 1'b1;
    @(negedge clk);
    check("midjump rst x",      32'(x),          32'd32);
    check("midjump rst y",      32'(y),          32'd440);
    check("midjump rst facing", 32'(facing),     32'd1);
    check("midjump rst jump",   32'(jumping),    32'd0);
    check("midjump rst anim",   32'(anim_frame), 32'd0);
    check("midjump rst tick",   32'(tick),       32'd0);
    rst = 1'b0;
    step(4'b1000, 1'b0, mk_e(32, 440, 1'b1, 1'b1, 0), "post rst jump");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
